// File: rtl/pulse_meter.sv
// Pulse-width meter: synchronises sig_in, times each high pulse in clocks and queues the widths.
// Optional `PULSE_METER_GLITCH_FILTER_EN drops pulses shorter than MIN_W and counts them.
module pulse_meter #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned MIN_W = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sig_in,
  input  logic                       en,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [CNT_W-1:0]           m_width,
  output logic                       m_sat,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       busy,
  output logic                       ovf,
`ifdef PULSE_METER_GLITCH_FILTER_EN
  output logic [7:0]                 glitch_cnt,
`endif
  input  logic                       clr_ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MIN_W > (2 ** CNT_W) - 1) begin : g_bad_param
    $error("pulse_meter: DEPTH must be a power of 2 >= 2 and MIN_W must fit in CNT_W bits");
  end

  typedef enum logic [0:0] {StIdle, StHigh} state_e;

  state_e            state_q, state_d;
  logic              s1_q, s2_q, s3_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic [CNT_W:0]    mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              rise, fall, push, pop, full, empty, wr, drop;

`ifdef PULSE_METER_GLITCH_FILTER_EN
  logic [7:0] glitch_q, glitch_d;
  assign glitch_cnt = glitch_q;
`endif

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    push    = 1'b0;
`ifdef PULSE_METER_GLITCH_FILTER_EN
    glitch_d = glitch_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (rise && en) begin
          state_d = StHigh;
          cnt_d   = CNT_W'(1);
          sat_d   = 1'b0;
        end
      end
      StHigh: begin
        if (fall) begin
          state_d = StIdle;
`ifdef PULSE_METER_GLITCH_FILTER_EN
          if (32'(cnt_q) < MIN_W) begin
            if (glitch_q != 8'hff) glitch_d = glitch_q + 8'd1;
          end else begin
            push = 1'b1;
          end
`else
          push = 1'b1;
`endif
        end else if (s2_q) begin
          // Saturate instead of wrapping so long pulses stay distinguishable.
          if (&cnt_q) sat_d = 1'b1;
          else        cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign pop   = ~empty & m_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr    = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    level_d = level_q;
    unique case ({wr, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef PULSE_METER_GLITCH_FILTER_EN
      glitch_q <= '0;
`endif
    end else begin
      s1_q    <= sig_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      if (wr) begin
        mem_q[wptr_q] <= {sat_q, cnt_q};
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
`ifdef PULSE_METER_GLITCH_FILTER_EN
      glitch_q <= glitch_d;
`endif
    end
  end

  assign m_valid          = ~empty;
  assign {m_sat, m_width} = empty ? '0 : mem_q[rptr_q];
  assign level            = level_q;
  assign busy             = (state_q == StHigh);
  assign ovf              = ovf_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: default instance plus a CNT_W=4 instance for saturation.
module tb_pulse_meter;

  logic       clk, reset, sig_in, en, m_ready, clr_ovf;
  logic       m_valid, m_sat, busy, ovf;
  logic [7:0] m_width;
  logic [2:0] level;
  logic       sig4, m_ready4, m_valid4, m_sat4, busy4, ovf4;
  logic [3:0] m_width4;
  logic [2:0] level4;
`ifdef PULSE_METER_GLITCH_FILTER_EN
  logic [7:0] gc, gc4;
  localparam int unsigned BaseW = 3;
`else
  localparam int unsigned BaseW = 2;
`endif

  int errors = 0;
  int checks = 0;
  int lat;

  pulse_meter #(.CNT_W(8), .DEPTH(4), .MIN_W(3)) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .en(en),
    .m_valid(m_valid), .m_ready(m_ready), .m_width(m_width), .m_sat(m_sat),
    .level(level), .busy(busy), .ovf(ovf),
`ifdef PULSE_METER_GLITCH_FILTER_EN
    .glitch_cnt(gc),
`endif
    .clr_ovf(clr_ovf)
  );

  pulse_meter #(.CNT_W(4), .DEPTH(4), .MIN_W(3)) dut4 (
    .clk(clk), .reset(reset), .sig_in(sig4), .en(en),
    .m_valid(m_valid4), .m_ready(m_ready4), .m_width(m_width4), .m_sat(m_sat4),
    .level(level4), .busy(busy4), .ovf(ovf4),
`ifdef PULSE_METER_GLITCH_FILTER_EN
    .glitch_cnt(gc4),
`endif
    .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    sig_in = 1'b1;
    repeat (n) tick();
    sig_in = 1'b0;
    repeat (5) tick();
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sig_in = 1'b0; en = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
    sig4 = 1'b0; m_ready4 = 1'b0;
    repeat (2) tick();
    check("rst_valid", 32'(m_valid), 0);
    check("rst_width", 32'(m_width), 0);
    check("rst_sat", 32'(m_sat), 0);
    check("rst_level", 32'(level), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovf", 32'(ovf), 0);
`ifdef PULSE_METER_GLITCH_FILTER_EN
    check("rst_glitch", 32'(gc), 0);
`endif
    reset = 1'b0;
    en = 1'b1;
    tick();

    // Single 5-cycle pulse and hand-off latency
    sig_in = 1'b1;
    repeat (5) tick();
    sig_in = 1'b0;
    lat = 0;
    while (!m_valid && lat < 8) begin
      tick();
      lat++;
    end
    check("valid_latency_ok", 32'(lat >= 2 && lat <= 4), 1);
    check("p5_width", 32'(m_width), 5);
    check("p5_sat", 32'(m_sat), 0);
    check("p5_level", 32'(level), 1);
    repeat (3) tick();
    check("p5_busy_done", 32'(busy), 0);
    pop_one();
    check("p5_pop_level", 32'(level), 0);
    check("p5_pop_valid", 32'(m_valid), 0);
    check("p5_empty_width", 32'(m_width), 0);
    pop_one();
    check("pop_empty_level", 32'(level), 0);

    // Saturation on the 4-bit instance, then the exact-max boundary
    sig4 = 1'b1;
    repeat (20) tick();
    sig4 = 1'b0;
    repeat (5) tick();
    check("sat20_width", 32'(m_width4), 15);
    check("sat20_sat", 32'(m_sat4), 1);
    m_ready4 = 1'b1; tick(); m_ready4 = 1'b0;
    sig4 = 1'b1;
    repeat (15) tick();
    sig4 = 1'b0;
    repeat (5) tick();
    check("max15_width", 32'(m_width4), 15);
    check("max15_sat", 32'(m_sat4), 0);

    // Overflow: five pulses into a 4-deep FIFO
    for (int i = 0; i < 5; i++) pulse(BaseW + i);
    check("ovf_level", 32'(level), 4);
    check("ovf_set", 32'(ovf), 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_drain%0d", i), 32'(m_width), BaseW + i);
      pop_one();
    end
    check("ovf_drain_level", 32'(level), 0);
    check("ovf_sticky", 32'(ovf), 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("ovf_clr", 32'(ovf), 0);

    // Full FIFO, push and pop in the same cycle
    for (int i = 7; i <= 10; i++) pulse(i);
    check("full_level", 32'(level), 4);
    sig_in = 1'b1;
    repeat (11) tick();
    sig_in = 1'b0;
    repeat (2) tick();
    check("full_busy_at_fall", 32'(busy), 1);
    pop_one();
    check("full_pp_level", 32'(level), 4);
    check("full_pp_ovf", 32'(ovf), 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_drain%0d", i), 32'(m_width), 8 + i);
      pop_one();
    end

    // Enable low at the rise: pulse is ignored even if enable returns mid-pulse
    en = 1'b0;
    sig_in = 1'b1;
    repeat (3) tick();
    en = 1'b1;
    repeat (4) tick();
    check("en0_busy", 32'(busy), 0);
    sig_in = 1'b0;
    repeat (5) tick();
    check("en0_level", 32'(level), 0);

    // Asynchronous reset mid-pulse flushes the FIFO and discards the measurement
    pulse(3);
    check("pre_rst_level", 32'(level), 1);
    sig_in = 1'b1;
    repeat (4) tick();
    check("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("async_rst_level", 32'(level), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_valid", 32'(m_valid), 0);
    reset = 1'b0;
    repeat (3) tick();
    sig_in = 1'b0;
    repeat (5) tick();
    check("partial_level", 32'(level), 1);
    check("partial_width", 32'(m_width), 3);
    pop_one();

`ifdef PULSE_METER_GLITCH_FILTER_EN
    pulse(1);
    pulse(2);
    pulse(3);
    check("glitch_level", 32'(level), 1);
    check("glitch_width", 32'(m_width), 3);
    check("glitch_cnt", 32'(gc), 2);
`else
    // Width-1 pulse back to back with a width-2 pulse
    sig_in = 1'b1; tick(); sig_in = 1'b0; tick();
    sig_in = 1'b1; repeat (2) tick(); sig_in = 1'b0;
    repeat (5) tick();
    check("b2b_level", 32'(level), 2);
    check("b2b_first", 32'(m_width), 1);
    pop_one();
    check("b2b_second", 32'(m_width), 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
